// File: rtl/project_pwm_config_loader_if.sv
// SPI slave pins plus the register-file port of the PWM configuration loader.
// The master modport is the loader's view, the slave modport is the view of
// whatever drives the SPI pins and supplies the register-file read data.
interface project_pwm_config_loader_if;
    logic       i_spi_sclk;
    logic       i_spi_cs_n;
    logic       i_spi_mosi;
    logic       o_spi_miso;
    logic [7:0] i_rdata;
    logic       o_write_en;
    logic [5:0] o_address;
    logic [7:0] o_data;
    logic       o_busy;

    modport master (
        input  i_spi_sclk, i_spi_cs_n, i_spi_mosi, i_rdata,
        output o_spi_miso, o_write_en, o_address, o_data, o_busy
    );

    modport slave (
        output i_spi_sclk, i_spi_cs_n, i_spi_mosi, i_rdata,
        input  o_spi_miso, o_write_en, o_address, o_data, o_busy
    );
endinterface

// File: rtl/project_pwm_config_loader.sv
// SPI (mode 0) to register-file bridge for the PWM configuration registers.
// Frame: one command byte {rw, auto_inc, addr[5:0]} followed by data bytes;
// each completed write byte produces a one-cycle write strobe.
// Optional build macro PWM_CONFIG_LOADER_READBACK_EN enables read frames
// (rw=1) that shift register-file contents out on MISO; without it rw is
// ignored and MISO is held at 0.
module project_pwm_config_loader (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    project_pwm_config_loader_if.master        bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_DATA  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam logic [2:0] LAST_BIT = 3'd7;

    state_t     state_q, state_d;
    // [0] first flop, [1] synchronized value, [2] previous synchronized value
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] cs_sync_q, cs_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [1:0] settle_q, settle_d;
    logic       armed_q, armed_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] cnt_q, cnt_d;
    logic [5:0] addr_q, addr_d;
    logic       ainc_q, ainc_d;
    logic [7:0] data_q, data_d;
    logic       we_q, we_d;
    logic       busy_q, busy_d;

    logic       sclk_rise_s;
    logic       cs_rise_s;
    logic       cs_fall_s;
    logic [7:0] rx_byte_s;

    assign sclk_rise_s = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign cs_rise_s   = cs_sync_q[1] & ~cs_sync_q[2];
    assign cs_fall_s   = ~cs_sync_q[1] & cs_sync_q[2];
    assign rx_byte_s   = {shift_q[6:0], mosi_sync_q[1]};

`ifdef PWM_CONFIG_LOADER_READBACK_EN
    logic       rw_q, rw_d;
    logic       load_q, load_d;
    logic       inc_q, inc_d;
    logic [7:0] miso_sh_q, miso_sh_d;
    logic       miso_q, miso_d;
    logic       sclk_fall_s;

    assign sclk_fall_s = ~sclk_sync_q[1] & sclk_sync_q[2];
`else
    logic       unused_rdata_s;

    assign unused_rdata_s = ^bus.i_rdata;
`endif

    // Next value of the raw-pin synchronizer chains.
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], bus.i_spi_sclk};
        cs_sync_d   = {cs_sync_q[1:0], bus.i_spi_cs_n};
        mosi_sync_d = {mosi_sync_q[0], bus.i_spi_mosi};
    end

    // Frame FSM, receive shifter, address tracking and write-strobe generation.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ainc_d   = ainc_q;
        data_d   = data_q;
        // A falling CS_n only counts once CS_n has been seen high through the
        // synchronizer after reset, so a frame cut by reset is not resumed.
        settle_d = (settle_q == 2'd3) ? settle_q : (settle_q + 2'd1);
        armed_d  = armed_q | (settle_q[1] & cs_sync_q[1]);
`ifdef PWM_CONFIG_LOADER_READBACK_EN
        rw_d     = rw_q;
        inc_d    = 1'b0;
        // Completed read byte: step the address, then fetch the next byte.
        if (inc_q) begin
            addr_d = ainc_q ? (addr_q + 6'd1) : addr_q;
            load_d = 1'b1;
        end else begin
            load_d = 1'b0;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (armed_q && cs_fall_s) begin
                    state_d = ST_CMD;
                    shift_d = 8'd0;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (sclk_rise_s) begin
                    shift_d = rx_byte_s;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_BIT) begin
                        addr_d  = rx_byte_s[5:0];
                        ainc_d  = rx_byte_s[6];
                        state_d = ST_DATA;
`ifdef PWM_CONFIG_LOADER_READBACK_EN
                        rw_d    = rx_byte_s[7];
                        load_d  = rx_byte_s[7];
`endif
                    end else begin
                        state_d = ST_CMD;
                    end
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_DATA: begin
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (sclk_rise_s) begin
                    shift_d = rx_byte_s;
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == LAST_BIT) begin
`ifdef PWM_CONFIG_LOADER_READBACK_EN
                        if (rw_q) begin
                            inc_d = 1'b1;
                        end else begin
                            data_d  = rx_byte_s;
                            state_d = ST_WRITE;
                        end
`else
                        data_d  = rx_byte_s;
                        state_d = ST_WRITE;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_WRITE: begin
                // The strobe is on this cycle; the address moves afterwards.
                addr_d = ainc_q ? (addr_q + 6'd1) : addr_q;
                if (cs_rise_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = ST_DATA;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        we_d   = (state_d == ST_WRITE);
    end

    // State, synchronizer and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            sclk_sync_q <= 3'b000;
            cs_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            shift_q     <= 8'd0;
            cnt_q       <= 3'd0;
            addr_q      <= 6'd0;
            ainc_q      <= 1'b0;
            data_q      <= 8'd0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ainc_q      <= ainc_d;
            data_q      <= data_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_write_en = we_q;
    assign bus.o_address  = addr_q;
    assign bus.o_data     = data_q;
    assign bus.o_busy     = busy_q;

`ifdef PWM_CONFIG_LOADER_READBACK_EN
    // MISO shifter: load register data, shift on SCLK falls inside a byte.
    always_comb begin
        if (state_q == ST_IDLE) begin
            miso_sh_d = 8'd0;
        end else if (load_q) begin
            miso_sh_d = bus.i_rdata;
        end else if (rw_q && (state_q == ST_DATA) && sclk_fall_s && (cnt_q != 3'd0)) begin
            miso_sh_d = {miso_sh_q[6:0], 1'b0};
        end else begin
            miso_sh_d = miso_sh_q;
        end
        miso_d = miso_sh_d[7];
    end

    // Readback registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rw_q      <= 1'b0;
            load_q    <= 1'b0;
            inc_q     <= 1'b0;
            miso_sh_q <= 8'd0;
            miso_q    <= 1'b0;
        end else begin
            rw_q      <= rw_d;
            load_q    <= load_d;
            inc_q     <= inc_d;
            miso_sh_q <= miso_sh_d;
            miso_q    <= miso_d;
        end
    end

    assign bus.o_spi_miso = miso_q;
`else
    assign bus.o_spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_project_pwm_config_loader.sv
// Bench for project_pwm_config_loader: directed frames plus random frames,
// checked against a frame-level model (expected strobe list / readback bytes).
// Honours PWM_CONFIG_LOADER_READBACK_EN for the read-frame scenarios.
module tb_project_pwm_config_loader;
    logic i_clk = 1'b0;
    logic i_rst_n;

    always #5 i_clk = ~i_clk;

    project_pwm_config_loader_if bus ();

    project_pwm_config_loader dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  mem [64];
    logic [7:0]  tx [8];
    logic [7:0]  rx [8];
    logic [13:0] obs_q [$];
    logic [13:0] exp_q [$];
    int          miso_high = 0;

    assign bus.i_rdata = mem[bus.o_address];

    // Record every strobe cycle and any MISO activity.
    always @(negedge i_clk) begin
        if (bus.o_write_en === 1'b1) obs_q.push_back({bus.o_address, bus.o_data});
        if (bus.o_spi_miso !== 1'b0) miso_high++;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic half_bit();
        repeat (4) @(negedge i_clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input int nb, output logic [7:0] r);
        r = 8'd0;
        for (int i = 0; i < nb; i++) begin
            bus.i_spi_mosi = b[7-i];
            half_bit();
            r = {r[6:0], bus.o_spi_miso};
            bus.i_spi_sclk = 1'b1;
            half_bit();
            bus.i_spi_sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int n, input int part);
        logic [7:0] r;
        bus.i_spi_cs_n = 1'b0;
        half_bit();
        send_bits(cmd, 8, r);
        for (int k = 0; k < n; k++) begin
            send_bits(tx[k], 8, r);
            rx[k] = r;
        end
        if (part > 0) send_bits(tx[n], part, r);
    endtask

    task automatic end_frame();
        half_bit();
        bus.i_spi_cs_n = 1'b1;
    endtask

    task automatic settle();
        repeat (10) @(negedge i_clk);
    endtask

    // Frame-level model: one strobe per complete write byte, address from the
    // command, +1 mod 64 per byte when auto_inc is set.
    task automatic model_frame(input logic [7:0] cmd, input int n);
        logic [5:0] a;
        a = cmd[5:0];
        for (int k = 0; k < n; k++) begin
`ifdef PWM_CONFIG_LOADER_READBACK_EN
            if (cmd[7]) check($sformatf("rd_byte%0d_a%0d", k, a), {8'd0, rx[k]}, {8'd0, mem[a]});
            else        exp_q.push_back({a, tx[k]});
`else
            exp_q.push_back({a, tx[k]});
`endif
            if (cmd[6]) a = a + 6'd1;
        end
    endtask

    task automatic compare_strobes(input string tag);
        check({tag, "_count"}, 16'(obs_q.size()), 16'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_strobe%0d", tag, i), {2'b00, obs_q[i]}, {2'b00, exp_q[i]});
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] cmd;
        logic [7:0] r;
        int         n;
        int         part;

        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[9] = 8'hC3;
        bus.i_spi_sclk = 1'b0;
        bus.i_spi_cs_n = 1'b1;
        bus.i_spi_mosi = 1'b0;
        i_rst_n = 1'b0;
        repeat (3) @(negedge i_clk);
        check("rst_we",   {15'd0, bus.o_write_en}, 16'd0);
        check("rst_addr", {10'd0, bus.o_address},  16'd0);
        check("rst_data", {8'd0, bus.o_data},      16'd0);
        check("rst_busy", {15'd0, bus.o_busy},     16'd0);
        check("rst_miso", {15'd0, bus.o_spi_miso}, 16'd0);
        i_rst_n = 1'b1;
        settle();

        // Single write: cmd 0x05, data 0xA5.
        tx[0] = 8'hA5;
        run_frame(8'h05, 1, 0);
        end_frame();
        settle();
        model_frame(8'h05, 1);
        compare_strobes("single");

        // Auto-increment across the 63 -> 0 wrap.
        tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
        run_frame(8'h7E, 3, 0);
        end_frame();
        settle();
        model_frame(8'h7E, 3);
        compare_strobes("autoinc");

        // Abort after 4 bits of the second data byte.
        tx[0] = 8'hFF; tx[1] = 8'h96;
        run_frame(8'h03, 1, 4);
        check("abort_busy_hi", {15'd0, bus.o_busy}, 16'd1);
        end_frame();
        repeat (3) @(negedge i_clk);
        check("abort_busy_lo", {15'd0, bus.o_busy}, 16'd0);
        settle();
        model_frame(8'h03, 1);
        compare_strobes("abort");

        // Reset in the middle of a data byte.
        bus.i_spi_cs_n = 1'b0;
        half_bit();
        send_bits(8'h21, 8, r);
        send_bits(8'hC7, 5, r);
        i_rst_n = 1'b0;
        #1;
        check("midrst_we",   {15'd0, bus.o_write_en}, 16'd0);
        check("midrst_addr", {10'd0, bus.o_address},  16'd0);
        check("midrst_data", {8'd0, bus.o_data},      16'd0);
        check("midrst_busy", {15'd0, bus.o_busy},     16'd0);
        check("midrst_miso", {15'd0, bus.o_spi_miso}, 16'd0);
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        // CS_n still low: no new falling edge, so nothing may be accepted.
        send_bits(8'h01, 8, r);
        send_bits(8'h77, 8, r);
        check("norearm_busy", {15'd0, bus.o_busy}, 16'd0);
        end_frame();
        settle();
        compare_strobes("midrst");
        tx[0] = 8'h3C;
        run_frame(8'h0A, 1, 0);
        end_frame();
        settle();
        model_frame(8'h0A, 1);
        compare_strobes("postrst");

        // Command 0x89: read frame with readback, write frame without.
`ifdef PWM_CONFIG_LOADER_READBACK_EN
        tx[0] = 8'h00;
        run_frame(8'h89, 1, 0);
        end_frame();
        settle();
        check("rd_c3", {8'd0, rx[0]}, 16'h00C3);
        model_frame(8'h89, 1);
        compare_strobes("read89");
`else
        miso_high = 0;
        tx[0] = 8'h5A;
        run_frame(8'h89, 1, 0);
        end_frame();
        settle();
        model_frame(8'h89, 1);
        compare_strobes("rwignored");
        check("miso_zero", 16'(miso_high), 16'd0);
`endif

        // Random frames, some cut short mid-byte.
        for (int f = 0; f < 24; f++) begin
            cmd  = 8'($urandom_range(0, 255));
            n    = $urandom_range(0, 4);
            part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int k = 0; k < 8; k++) tx[k] = 8'($urandom_range(0, 255));
            run_frame(cmd, n, part);
            end_frame();
            settle();
            model_frame(cmd, n);
            compare_strobes($sformatf("rand%0d", f));
        end
`ifndef PWM_CONFIG_LOADER_READBACK_EN
        check("miso_zero_all", 16'(miso_high), 16'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
